vga_timing_ctrl: RTL and testbench

- Generates VGA 640x480 raster timing for the downstream bitgen stages, which consume bright, hcount and vcount.
- Produces active-low hsync/vsync for the DAC/connector, plus a one-clock frame_start strobe for frame-synchronous logic.
- Runs from the board clock and derives the pixel rate internally with a clock-enable, not a derived clock.
- Column convention: first visible column is hcount = 158, so downstream x = hcount - 158. First visible row is vcount = 0, so y = vcount.

---
 rtl/vga_timing_pkg.sv | 31 +++
 rtl/vga_timing_ctrl_if.sv | 18 +
 rtl/pixel_tick_gen.sv | 37 +++
 rtl/vga_timing_ctrl.sv | 84 ++++++++
 tb/tb_vga_timing_ctrl.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480 raster timing constants and decode helpers, used by the timing
// generator and the downstream bitgen stages.
package vga_timing_pkg;

    localparam int CNT_W = 10;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t H_TOTAL      = 10'd800;
    localparam cnt_t H_SYNC       = 10'd96;
    localparam cnt_t H_DISP_START = 10'd158;
    localparam cnt_t H_DISP_END   = 10'd798;

    localparam cnt_t V_TOTAL      = 10'd525;
    localparam cnt_t V_DISP_END   = 10'd480;
    localparam cnt_t V_SYNC_START = 10'd490;
    localparam cnt_t V_SYNC_LEN   = 10'd2;

    // Downstream x = hcount - X_OFFSET
    localparam cnt_t X_OFFSET = H_DISP_START;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic bright;
    } sync_t;

    function automatic logic in_window(cnt_t v, cnt_t lo, cnt_t hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/vga_timing_ctrl_if.sv
// Raster timing bundle: the generator drives it, bitgen stages and the DAC consume it.
interface vga_timing_ctrl_if;
    logic [9:0] hcount;
    logic [9:0] vcount;
    logic       hsync;
    logic       vsync;
    logic       bright;
    logic       pix_en;
    logic       frame_start;

    modport master (
        output hcount, vcount, hsync, vsync, bright, pix_en, frame_start
    );

    modport slave (
        input hcount, vcount, hsync, vsync, bright, pix_en, frame_start
    );
endinterface

// File: rtl/pixel_tick_gen.sv
// Divides the board clock into a one-clk pixel enable pulse every CLK_DIV clocks.
module pixel_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    output logic pix_en
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;
    logic          pix_en_reg;

    always_comb begin
        cnt_next = cnt_reg + CW'(1);
        if (cnt_reg == LAST) begin
            cnt_next = '0;
        end
    end

    // Registered from the next count so pix_en is high while the counter sits at LAST
    // and stays low throughout reset, even when CLK_DIV is 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg    <= '0;
            pix_en_reg <= 1'b0;
        end else begin
            cnt_reg    <= cnt_next;
            pix_en_reg <= (cnt_next == LAST);
        end
    end

    assign pix_en = pix_en_reg;

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing generator: pixel-enabled h/v counters with registered sync,
// bright and frame_start decode aligned to the counter outputs.
module vga_timing_ctrl #(
    parameter int         CLK_DIV      = 2,
    parameter logic [9:0] H_TOTAL      = vga_timing_pkg::H_TOTAL,
    parameter logic [9:0] H_SYNC       = vga_timing_pkg::H_SYNC,
    parameter logic [9:0] H_DISP_START = vga_timing_pkg::H_DISP_START,
    parameter logic [9:0] H_DISP_END   = vga_timing_pkg::H_DISP_END,
    parameter logic [9:0] V_TOTAL      = vga_timing_pkg::V_TOTAL,
    parameter logic [9:0] V_DISP_END   = vga_timing_pkg::V_DISP_END,
    parameter logic [9:0] V_SYNC_START = vga_timing_pkg::V_SYNC_START,
    parameter logic [9:0] V_SYNC_LEN   = vga_timing_pkg::V_SYNC_LEN
) (
    input  logic               clk,
    input  logic               rst,
    vga_timing_ctrl_if.master  vga
);
    import vga_timing_pkg::*;

    localparam cnt_t V_SYNC_END = V_SYNC_START + V_SYNC_LEN;

    logic  pix_en;
    cnt_t  h_reg, h_next;
    cnt_t  v_reg, v_next;
    sync_t dec_reg, dec_next;
    logic  fs_reg, fs_next;
    logic  h_wrap, v_wrap;

    pixel_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .pix_en (pix_en)
    );

    always_comb begin
        h_next  = h_reg;
        v_next  = v_reg;
        fs_next = 1'b0;
        h_wrap  = (h_reg == H_TOTAL - 10'd1);
        v_wrap  = (v_reg == V_TOTAL - 10'd1);
        if (pix_en) begin
            if (h_wrap) begin
                h_next = '0;
                if (v_wrap) begin
                    v_next  = '0;
                    fs_next = 1'b1;
                end else begin
                    v_next = v_reg + 10'd1;
                end
            end else begin
                h_next = h_reg + 10'd1;
            end
        end
        // Decode from the next counts so the registered flags line up with hcount/vcount.
        dec_next.hsync  = !(h_next < H_SYNC);
        dec_next.vsync  = !in_window(v_next, V_SYNC_START, V_SYNC_END);
        dec_next.bright = in_window(h_next, H_DISP_START, H_DISP_END) && (v_next < V_DISP_END);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_reg   <= '0;
            v_reg   <= '0;
            dec_reg <= '{hsync: 1'b0, vsync: 1'b1, bright: 1'b0};
            fs_reg  <= 1'b0;
        end else begin
            h_reg   <= h_next;
            v_reg   <= v_next;
            dec_reg <= dec_next;
            fs_reg  <= fs_next;
        end
    end

    assign vga.hcount      = h_reg;
    assign vga.vcount      = v_reg;
    assign vga.hsync       = dec_reg.hsync;
    assign vga.vsync       = dec_reg.vsync;
    assign vga.bright      = dec_reg.bright;
    assign vga.pix_en      = pix_en;
    assign vga.frame_start = fs_reg;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: full-size raster (CLK_DIV=2) checked against a vector
// table over the first lines, plus a reduced raster (CLK_DIV=1) run for whole frames.
module tb_vga_timing_ctrl;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;

    always #5 clk = ~clk;

    vga_timing_ctrl_if bus_a ();
    vga_timing_ctrl_if bus_b ();

    vga_timing_ctrl #(
        .CLK_DIV (2)
    ) dut_a (
        .clk (clk),
        .rst (rst_a),
        .vga (bus_a)
    );

    // Reduced raster: 12 columns x 8 lines, one clock per pixel -> 96 clks per frame.
    vga_timing_ctrl #(
        .CLK_DIV      (1),
        .H_TOTAL      (10'd12),
        .H_SYNC       (10'd3),
        .H_DISP_START (10'd5),
        .H_DISP_END   (10'd10),
        .V_TOTAL      (10'd8),
        .V_DISP_END   (10'd5),
        .V_SYNC_START (10'd6),
        .V_SYNC_LEN   (10'd1)
    ) dut_b (
        .clk (clk),
        .rst (rst_b),
        .vga (bus_b)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_a(input string tag, input int h, input int v, input int hs,
                         input int vs, input int br, input int pe, input int fs);
        chk({tag, "_hcount"}, int'(bus_a.hcount), h);
        chk({tag, "_vcount"}, int'(bus_a.vcount), v);
        chk({tag, "_hsync"}, int'(bus_a.hsync), hs);
        chk({tag, "_vsync"}, int'(bus_a.vsync), vs);
        chk({tag, "_bright"}, int'(bus_a.bright), br);
        chk({tag, "_pix_en"}, int'(bus_a.pix_en), pe);
        chk({tag, "_frame_start"}, int'(bus_a.frame_start), fs);
    endtask

    task automatic chk_b(input string tag, input int h, input int v, input int hs,
                         input int vs, input int br, input int pe, input int fs);
        chk({tag, "_hcount"}, int'(bus_b.hcount), h);
        chk({tag, "_vcount"}, int'(bus_b.vcount), v);
        chk({tag, "_hsync"}, int'(bus_b.hsync), hs);
        chk({tag, "_vsync"}, int'(bus_b.vsync), vs);
        chk({tag, "_bright"}, int'(bus_b.bright), br);
        chk({tag, "_pix_en"}, int'(bus_b.pix_en), pe);
        chk({tag, "_frame_start"}, int'(bus_b.frame_start), fs);
    endtask

    // k = clk edges after reset release; expected outputs sampled 1 ns after edge k.
    typedef struct {
        int k;
        int h;
        int v;
        int hs;
        int vs;
        int br;
        int pe;
        int fs;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int cur;
        int p, eh, ev;
        int trk_err, hs_low, br_cnt, vs_low, br_bad, pe_low, range_bad, fs_n;
        int fs_k[4];

        tbl[0]  = '{0,    0,   0, 0, 1, 0, 0, 0};
        tbl[1]  = '{1,    0,   0, 0, 1, 0, 1, 0};
        tbl[2]  = '{2,    1,   0, 0, 1, 0, 0, 0};
        tbl[3]  = '{191,  95,  0, 0, 1, 0, 1, 0};
        tbl[4]  = '{192,  96,  0, 1, 1, 0, 0, 0};
        tbl[5]  = '{315,  157, 0, 1, 1, 0, 1, 0};
        tbl[6]  = '{316,  158, 0, 1, 1, 1, 0, 0};
        tbl[7]  = '{1595, 797, 0, 1, 1, 1, 1, 0};
        tbl[8]  = '{1596, 798, 0, 1, 1, 0, 0, 0};
        tbl[9]  = '{1599, 799, 0, 1, 1, 0, 1, 0};
        tbl[10] = '{1600, 0,   1, 0, 1, 0, 0, 0};
        tbl[11] = '{1916, 158, 1, 1, 1, 1, 0, 0};

        // Reset state of both builds while reset is held.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_a("a_reset", 0, 0, 0, 1, 0, 0, 0);
        chk_b("b_reset", 0, 0, 0, 1, 0, 0, 0);
        $display("reset state checked for both builds");

        // Full-size raster, CLK_DIV=2: table of boundary points over the first lines.
        rst_a = 1'b0;
        cur = 0;
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].k > cur) begin
                repeat (tbl[i].k - cur) @(posedge clk);
                #1;
                cur = tbl[i].k;
            end
            chk_a($sformatf("a_k%0d", tbl[i].k), tbl[i].h, tbl[i].v, tbl[i].hs,
                  tbl[i].vs, tbl[i].br, tbl[i].pe, tbl[i].fs);
            $display("a vector k=%0d h=%0d v=%0d", tbl[i].k, bus_a.hcount, bus_a.vcount);
        end

        // Asynchronous reset off the clock edge, mid-line at hcount 158.
        @(posedge clk);
        #3;
        rst_a = 1'b1;
        #1;
        chk_a("a_async_rst", 0, 0, 0, 1, 0, 0, 0);
        $display("a async reset mid-line checked");

        // Reduced raster, CLK_DIV=1: three full frames.
        @(negedge clk);
        rst_b = 1'b0;
        trk_err = 0; hs_low = 0; br_cnt = 0; vs_low = 0;
        br_bad = 0; pe_low = 0; range_bad = 0; fs_n = 0;
        for (int k = 1; k <= 290; k++) begin
            @(posedge clk);
            #1;
            p  = (k - 1) % 96;
            eh = p % 12;
            ev = p / 12;
            if (k <= 288) begin
                if (int'(bus_b.hcount) != eh || int'(bus_b.vcount) != ev) trk_err++;
                if (!bus_b.hsync) hs_low++;
                if (!bus_b.vsync) vs_low++;
                if (bus_b.bright) br_cnt++;
                if (bus_b.bright && bus_b.vcount >= 10'd5) br_bad++;
                if (!bus_b.pix_en) pe_low++;
                if (bus_b.hcount > 10'd11 || bus_b.vcount > 10'd7) range_bad++;
            end
            if (bus_b.frame_start) begin
                if (fs_n < 4) fs_k[fs_n] = k;
                fs_n++;
            end
        end
        chk("b_counter_track_errors", trk_err, 0);
        chk("b_hsync_low_clks", hs_low, 72);
        chk("b_vsync_low_clks", vs_low, 36);
        chk("b_bright_clks", br_cnt, 75);
        chk("b_bright_outside_rows", br_bad, 0);
        chk("b_pix_en_low_clks", pe_low, 0);
        chk("b_range_violations", range_bad, 0);
        chk("b_frame_start_count", fs_n, 3);
        if (fs_n >= 3) begin
            chk("b_frame_start_first_k", fs_k[0], 97);
            chk("b_frame_start_period1", fs_k[1] - fs_k[0], 96);
            chk("b_frame_start_period2", fs_k[2] - fs_k[1], 96);
        end
        $display("b three frames: frame_start pulses=%0d hsync_low=%0d vsync_low=%0d bright=%0d",
                 fs_n, hs_low, vs_low, br_cnt);

        // Advance to (7,3) of the fourth frame, then reset asynchronously.
        repeat (42) @(posedge clk);
        #1;
        chk_b("b_pre_rst", 7, 3, 1, 1, 1, 1, 0);
        @(posedge clk);
        #3;
        rst_b = 1'b1;
        #1;
        chk_b("b_async_rst", 0, 0, 0, 1, 0, 0, 0);
        $display("b async reset mid-frame checked");

        // Restart: same opening sequence, and no stray frame_start within the first frame.
        @(negedge clk);
        rst_b = 1'b0;
        fs_n = 0;
        for (int k = 1; k <= 96; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) chk_b("b_restart_k1", 0, 0, 0, 1, 0, 1, 0);
            if (k == 2) chk_b("b_restart_k2", 1, 0, 0, 1, 0, 1, 0);
            if (bus_b.frame_start) fs_n++;
        end
        chk("b_restart_no_frame_start", fs_n, 0);
        $display("b restart after reset checked");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
